many_frequencies_detector: RTL
==============================

# many_frequencies_detector

Receive-side counterpart of the selectable-rate tick divider. It watches an incoming tick train, such as a divided clock pulse from another board or pin, and measures the clock-cycle distance between rising edges. It classifies that distance against the four divider rates and reports the 2-bit select code that would have produced it. Lock requires two consecutive matching periods and is dropped on mismatch or loss of ticks.

## Interface
Parameters:
- PERIOD0, 25000001, expected rising-to-rising distance for code 2'b00
- PERIOD1, 50000001, expected distance for code 2'b01
- PERIOD2, 100000001, expected distance for code 2'b10
- PERIOD3, 300000001, expected distance for code 2'b11
- TOLERANCE, 16, allowed absolute deviation in cycles
- TIMEOUT, 300000018, count value at which the tick train is declared lost

Ports:
- clock  input  1  single system clock, all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- tick_in  input  1  incoming tick, asynchronous to clock, any high width ≥1 cycle
- select_out  output  2  code of the last locked class
- locked  output  1  high while the tick train matches select_out
- period  output  29  last measured distance in cycles
- period_valid  output  1  one-cycle pulse when period updates
- mismatch  output  1  one-cycle pulse when a measured period breaks or fails confirmation

## Operation
- Input path:
  - tick_in passes through a 2-flop synchronizer, then a third flop.
  - strobe = sync2 & ~sync3, so each rising edge counts once regardless of high width.
- Counter: 29-bit count.
  - On strobe, count <= 1; otherwise count <= count + 1, saturating at 2^29-1.
  - Measured P = count on the strobe cycle.
- Class match:
  - P matches class i when |P - PERIODi| ≤ TOLERANCE.
  - Use 29-bit unsigned compare, with no wrap in the difference.
  - If several classes match, the lowest index wins. Parameters shall not overlap.
- State machine:
  - SEARCH:
    - strobe → ACQUIRE.
    - No period_valid.
  - ACQUIRE:
    - strobe and P matches c → CONFIRM, cand <= c.
    - strobe with no match → mismatch pulse, stay in ACQUIRE.
  - CONFIRM:
    - strobe and P matches cand → LOCKED, select_out <= cand, locked <= 1.
    - P matches another class c' → mismatch pulse, cand <= c', stay in CONFIRM.
    - No match → mismatch pulse, go to ACQUIRE.
  - LOCKED:
    - strobe and P matches select_out → stay in LOCKED.
    - Otherwise → mismatch pulse, locked <= 0, go to CONFIRM (cand <= c) if P matches class c, else ACQUIRE.
  - Any state except SEARCH:
    - No strobe and count == TIMEOUT → SEARCH, locked <= 0, no mismatch pulse.
- Outputs on strobe:
  - In every state except SEARCH: period <= P and period_valid pulses.
- select_out holds its value after lock loss until the next lock.
- Reset:
  - All outputs are 0; state SEARCH; count 0; cand 0; synchronizer flops 0.
  - Reset mid-operation discards any partial measurement.

## Timing
- tick_in first sampled high at clock edge N gives strobe during the cycle after edge N+1.
- Registered outputs change at edge N+2, so input-to-output latency is 3 edges.
- For two strobes S cycles apart, P = S exactly. Synchronizer delay cancels.
- period_valid and mismatch are single-cycle pulses, coincident with the period/locked update.
- Simultaneous strobe and count == TIMEOUT: the strobe wins and no timeout occurs.
- Lock needs 3 rising edges (2 matching periods).
- Lock loss is immediate on the first bad strobe, or at TIMEOUT.
- Saturation only matters if TIMEOUT > 2^29-1. Parameters shall keep TIMEOUT < 2^29-1.

## Test plan
Use overridden parameters: PERIOD0=10, PERIOD1=20, PERIOD2=40, PERIOD3=120, TOLERANCE=1, TIMEOUT=122.
- **Basic lock.** Reset, then 1-cycle tick_in pulses every 20 cycles.
  - 2nd pulse: period_valid with period=20, locked=0.
  - 3rd pulse: locked=1, select_out=01.
  - Each update appears 3 edges after its pulse.
- **Tolerance.** While locked on 20, send periods 19, 21, 19.
  - locked stays 1, no mismatch.
  - Then a period of 22 → mismatch pulse, locked=0, period=22.
- **Rate change.** Locked on 20, switch to period 40.
  - First 40 → mismatch, locked=0.
  - Second 40 → locked=1, select_out=10.
- **Timeout.** Lock on 10, then stop ticks.
  - locked falls when count reaches 122, with no mismatch.
  - The next pulse produces no period_valid.
- **Wide pulse.** tick_in held high 5 cycles, rising edges every 120 cycles.
  - One strobe per edge, period=120.
  - select_out=11 after 3 edges.
- **Reset mid-lock.** reset_n low for 1 cycle while locked.
  - All outputs are 0 on the next edge.
  - Re-lock needs 3 fresh edges.

Source files
------------

// File: rtl/many_frequencies_detector.sv
// many_frequencies_detector
//   Measures the clock-cycle distance between rising edges of an incoming
//   tick train, classifies it against four nominal periods, and reports
//   the 2-bit select code of the class once two consecutive periods agree.
//
// Ports
//   clock        in   system clock, all logic on posedge
//   reset_n      in   synchronous active-low reset
//   tick_in      in   asynchronous tick, any high width >= 1 cycle
//   select_out   out  [1:0]  code of the last locked class
//   locked       out  high while the tick train matches select_out
//   period       out  [28:0] last measured rising-to-rising distance
//   period_valid out  one-cycle pulse when period updates
//   mismatch     out  one-cycle pulse when a measured period breaks lock
//                     or fails confirmation
module many_frequencies_detector #(
    parameter int unsigned PERIOD0   = 25000001,
    parameter int unsigned PERIOD1   = 50000001,
    parameter int unsigned PERIOD2   = 100000001,
    parameter int unsigned PERIOD3   = 300000001,
    parameter int unsigned TOLERANCE = 16,
    parameter int unsigned TIMEOUT   = 300000018
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick_in,
    output logic [1:0]  select_out,
    output logic        locked,
    output logic [28:0] period,
    output logic        period_valid,
    output logic        mismatch
);

    localparam logic [28:0] P0_C   = 29'(PERIOD0);
    localparam logic [28:0] P1_C   = 29'(PERIOD1);
    localparam logic [28:0] P2_C   = 29'(PERIOD2);
    localparam logic [28:0] P3_C   = 29'(PERIOD3);
    localparam logic [28:0] TOL_C  = 29'(TOLERANCE);
    localparam logic [28:0] TOUT_C = 29'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_CONFIRM,
        ST_LOCKED
    } state_e;

    // Input synchronizer and edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic strobe;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= tick_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign strobe = sync2_q & ~sync3_q;

    // Distance counter: restarts at 1 on each strobe so the value seen on
    // the next strobe equals the strobe-to-strobe spacing exactly.
    logic [28:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (strobe) begin
            count_q <= 29'd1;
        end else if (count_q != '1) begin
            count_q <= count_q + 29'd1;
        end
    end

    // Class match, difference taken in the non-wrapping direction
    function automatic logic in_tol(input logic [28:0] p, input logic [28:0] nom);
        logic [28:0] diff;
        diff = (p >= nom) ? (p - nom) : (nom - p);
        return (diff <= TOL_C);
    endfunction

    logic [3:0] match;
    logic       any_match;
    logic [1:0] match_code;

    always_comb begin
        match[0] = in_tol(count_q, P0_C);
        match[1] = in_tol(count_q, P1_C);
        match[2] = in_tol(count_q, P2_C);
        match[3] = in_tol(count_q, P3_C);
        any_match = |match;
        // Lowest index wins
        match_code = 2'd0;
        if (match[0])      match_code = 2'd0;
        else if (match[1]) match_code = 2'd1;
        else if (match[2]) match_code = 2'd2;
        else if (match[3]) match_code = 2'd3;
    end

    // Classification FSM and registered outputs
    state_e      state_q, state_d;
    logic [1:0]  cand_q, cand_d;
    logic [1:0]  select_q, select_d;
    logic        locked_q, locked_d;
    logic [28:0] period_q, period_d;
    logic        pvalid_q, pvalid_d;
    logic        mism_q, mism_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_SEARCH;
            cand_q   <= '0;
            select_q <= '0;
            locked_q <= 1'b0;
            period_q <= '0;
            pvalid_q <= 1'b0;
            mism_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            select_q <= select_d;
            locked_q <= locked_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
            mism_q   <= mism_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        select_d = select_q;
        locked_d = locked_q;
        period_d = period_q;
        pvalid_d = 1'b0;
        mism_d   = 1'b0;

        if (strobe) begin
            if (state_q != ST_SEARCH) begin
                period_d = count_q;
                pvalid_d = 1'b1;
            end
            case (state_q)
                ST_SEARCH: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (any_match) begin
                        state_d = ST_CONFIRM;
                        cand_d  = match_code;
                    end else begin
                        mism_d = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (match[cand_q]) begin
                        state_d  = ST_LOCKED;
                        select_d = cand_q;
                        locked_d = 1'b1;
                    end else if (any_match) begin
                        mism_d = 1'b1;
                        cand_d = match_code;
                    end else begin
                        mism_d  = 1'b1;
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    if (!match[select_q]) begin
                        mism_d   = 1'b1;
                        locked_d = 1'b0;
                        if (any_match) begin
                            state_d = ST_CONFIRM;
                            cand_d  = match_code;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end else if (state_q != ST_SEARCH && count_q == TOUT_C) begin
            // Tick train lost: silent drop back to search
            state_d  = ST_SEARCH;
            locked_d = 1'b0;
        end
    end

    assign select_out   = select_q;
    assign locked       = locked_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign mismatch     = mism_q;

endmodule
